// File: rtl/bin2bcd_converter.sv
// Sequential 32-bit binary to 8-digit packed BCD converter (double dabble, one iteration per clock).
// Operands above 99_999_999 complete with the same latency, report ERR_PATTERN on bcd and raise ovf.
module bin2bcd_converter #(
  parameter logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bin,
  output logic [31:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam logic [31:0] MAX_IN_RANGE = 32'd99_999_999;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] sr_q;
  logic        range_q;
  logic [31:0] bcd_q;
  logic        ovf_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] adj_bcd;
  logic [63:0] sr_d;

  // Add-3 correction on each BCD nibble; values 5..9 map to 8..12, so 4 bits suffice.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      logic [3:0] nib;
      assign nib = sr_q[32 + 4*gi +: 4];
      assign adj_bcd[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  // Bits leaving the top of the BCD field are discarded by the shift.
  assign sr_d = {adj_bcd, sr_q[31:0]} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      sr_q    <= 64'h0;
      range_q <= 1'b0;
      bcd_q   <= 32'h0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= {32'h0, bin};
            cnt_q   <= 5'd31;
            range_q <= (bin > MAX_IN_RANGE);
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            bcd_q   <= range_q ? ERR_PATTERN : sr_d[63:32];
            ovf_q   <= range_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Randomized self-checking bench for bin2bcd_converter against a decimal-arithmetic reference model.
module tb_bin2bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bin = 32'h0;
  logic [31:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  bin2bcd_converter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, error pattern when out of range.
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r;
    int unsigned x;
    if (v > 32'd99_999_999) return 32'hEEEE_EEEE;
    r = 32'h0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Drives one request from posedge+1; returns latency and observed results. Ends at posedge+1.
  task automatic convert(input logic [31:0] v, output int lat, output logic [31:0] b,
                         output logic o, output bit busy_ok, output bit hold_ok,
                         output bit pulse_ok);
    logic [31:0] prev;
    prev = bcd;
    lat = -1; b = 32'hx; o = 1'bx;
    busy_ok = 1; hold_ok = 1; pulse_ok = 1;
    start = 1'b1;
    bin = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin = $urandom;
    for (int c = 1; c <= 40; c++) begin
      if (!busy || done) busy_ok = 0;
      if (bcd !== prev) hold_ok = 0;
      @(posedge clk); #1;
      if (done) begin
        lat = c; b = bcd; o = ovf;
        if (busy) busy_ok = 0;
        break;
      end
    end
    @(posedge clk); #1;
    if (done) pulse_ok = 0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if (bcd !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bcd=%h busy=%b done=%b ovf=%b required bcd=0 busy=0 done=0 ovf=0",
               bcd, busy, done, ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released: bcd=%h busy=%b", bcd, busy);
  endtask

  task automatic test_value(input string name, input logic [31:0] v);
    int lat; logic [31:0] b; logic o; bit bok, hok, pok;
    logic [31:0] exp_b; logic exp_o;
    exp_b = ref_bcd(v);
    exp_o = (v > 32'd99_999_999);
    convert(v, lat, b, o, bok, hok, pok);
    $display("%s: bin=%0d bcd=%h ovf=%b latency=%0d", name, v, b, o, lat);
    checks++;
    if (lat != 32) begin
      errors++; $display("FAIL %s_latency: got %0d required 32", name, lat);
    end
    checks++;
    if (b !== exp_b || o !== exp_o) begin
      errors++;
      $display("FAIL %s_result: bcd=%h ovf=%b required bcd=%h ovf=%b", name, b, o, exp_b, exp_o);
    end
    checks++;
    if (!bok || !hok || !pok) begin
      errors++;
      $display("FAIL %s_handshake: busy_ok=%0b hold_ok=%0b pulse_ok=%0b required 1 1 1",
               name, bok, hok, pok);
    end
  endtask

  task automatic test_ignore_start;
    int ndone = 0; int lat = -1; logic [31:0] b = 32'h0;
    start = 1'b1; bin = 32'h4D2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 75; c++) begin
      if (c == 5) begin start = 1'b1; bin = 32'd9; end
      if (c == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin ndone++; lat = c; b = bcd; end
    end
    $display("ignore_start: dones=%0d latency=%0d bcd=%h", ndone, lat, b);
    checks++;
    if (ndone != 1 || lat != 32) begin
      errors++; $display("FAIL ignore_start_done: count=%0d latency=%0d required 1 and 32", ndone, lat);
    end
    checks++;
    if (bcd !== 32'h00001234) begin
      errors++; $display("FAIL ignore_start_bcd: got %h required 00001234", bcd);
    end
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    int lat; logic [31:0] b; logic o; bit bok, hok, pok;
    start = 1'b1; bin = 32'h00BC614E;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    checks++;
    if (bcd !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: bcd=%h busy=%b done=%b ovf=%b required all zero", bcd, busy, done, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    $display("reset_abort: activity cycles after abort=%0d", ndone);
    checks++;
    if (ndone != 0) begin
      errors++; $display("FAIL abort_no_done: activity=%0d required 0", ndone);
    end
    convert(32'h00BC614E, lat, b, o, bok, hok, pok);
    $display("restart: bcd=%h latency=%0d", b, lat);
    checks++;
    if (b !== 32'h12345678 || lat != 32) begin
      errors++; $display("FAIL restart: bcd=%h latency=%0d required 12345678 and 32", b, lat);
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    start = 1'b1; bin = 32'hFF;
    @(posedge clk); #1;
    for (int c = 1; c <= 140; c++) begin
      @(posedge clk); #1;
      if (done) begin
        $display("back_to_back: done at cycle %0d bcd=%h", c, bcd);
        checks++;
        if (c != 32 + 33*ndone || bcd !== 32'h00000255) begin
          errors++;
          $display("FAIL back_to_back_%0d: cycle=%0d bcd=%h required cycle=%0d bcd=00000255",
                   ndone, c, bcd, 32 + 33*ndone);
        end
        ndone++;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 4) begin
      errors++; $display("FAIL back_to_back_count: got %0d required 4", ndone);
    end
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = (i % 4 == 3) ? $urandom : $urandom_range(99_999_999, 0);
      test_value("random", v);
    end
  endtask

  initial begin
    test_reset();
    test_value("zero", 32'h0);
    test_value("known", 32'h00BC614E);
    test_value("max_in_range", 32'h05F5E0FF);
    test_value("first_ovf", 32'h05F5E100);
    test_value("all_ones", 32'hFFFF_FFFF);
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
